switch_value_encoder: RTL and testbench

//  Inverse of the selector->register switch decoder: accepts 8-bit register

---
 rtl/switch_value_encoder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_switch_value_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_value_encoder.sv
// ---------------------------------------------------------------------------
// switch_value_encoder
//
// Purpose:
//   Inverse of the selector->register switch decoder. Each accepted 8-bit
//   register value is mapped back to the selector code that produces it:
//     17 -> 0, 22 -> 1, 30 -> 2, 72 -> 3
//   72 is produced by selectors 3..6, so the lowest of them, 3, is emitted.
//   Any other value is a miss: the selector is forced to 0 and hit = 0.
//   Results are queued in a small output FIFO. A sticky flag records misses.
//
// Optional feature:
//   SWITCH_VALUE_ENCODER_STATS_EN - when defined, adds saturating hit/miss
//   counters and the hit_count / miss_count ports. When it is not defined,
//   those ports and the counter logic are absent.
//
// Ports:
//   clock        in   1           global clock, rising edge
//   reset        in   1           asynchronous, active-high
//   in_valid     in   1           in_value is valid this cycle
//   in_ready     out  1           encoder can accept (FIFO not full)
//   in_value     in   DATA_WIDTH  register value to encode
//   out_valid    out  1           FIFO head valid
//   out_ready    in   1           consumer takes head this cycle
//   out_sel      out  SEL_WIDTH   recovered selector at FIFO head
//   out_hit      out  1           1 = value matched table, 0 = out_sel forced 0
//   miss_sticky  out  1           set on any accepted miss, cleared by miss_clear
//   miss_clear   in   1           synchronous clear of miss_sticky
//   hit_count    out  CNT_WIDTH   (stats build only) accepted hits
//   miss_count   out  CNT_WIDTH   (stats build only) accepted misses
//
// All outputs are driven directly from registers. The next head value is
// computed ahead of the clock edge so out_sel/out_hit never depend
// combinationally on the inputs.
// ---------------------------------------------------------------------------
module switch_value_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int FIFO_DEPTH = 2
`ifdef SWITCH_VALUE_ENCODER_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_WIDTH-1:0]  out_sel,
    output logic                  out_hit,
    output logic                  miss_sticky,
    input  logic                  miss_clear
`ifdef SWITCH_VALUE_ENCODER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
`endif
);

    // -----------------------------------------------------------------------
    // Derived sizes and constants
    // -----------------------------------------------------------------------
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W = PTR_W + 1;
    localparam int ENTRY_W = SEL_WIDTH + 1;   // {sel, hit}

    localparam logic [COUNT_W-1:0] COUNT_FULL  = COUNT_W'(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_EMPTY = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] COUNT_ONE   = COUNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE     = PTR_W'(1);
    localparam logic [ENTRY_W-1:0] ENTRY_ZERO  = {ENTRY_W{1'b0}};

    localparam logic [DATA_WIDTH-1:0] VALUE_SEL0 = DATA_WIDTH'(17);
    localparam logic [DATA_WIDTH-1:0] VALUE_SEL1 = DATA_WIDTH'(22);
    localparam logic [DATA_WIDTH-1:0] VALUE_SEL2 = DATA_WIDTH'(30);
    localparam logic [DATA_WIDTH-1:0] VALUE_SEL3 = DATA_WIDTH'(72);

    localparam logic [SEL_WIDTH-1:0] SEL_0 = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_1 = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_2 = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SEL_3 = SEL_WIDTH'(3);

    // -----------------------------------------------------------------------
    // Encode table: returns {sel, hit}. Value 72 is shared by selectors
    // 3..6 in the forward decoder; the canonical (lowest) selector is used.
    // -----------------------------------------------------------------------
    function automatic logic [ENTRY_W-1:0] encode_value(
        input logic [DATA_WIDTH-1:0] value
    );
        logic [ENTRY_W-1:0] result;
        result = {SEL_0, 1'b0};
        case (value)
            VALUE_SEL0: result = {SEL_0, 1'b1};
            VALUE_SEL1: result = {SEL_1, 1'b1};
            VALUE_SEL2: result = {SEL_2, 1'b1};
            VALUE_SEL3: result = {SEL_3, 1'b1};
            default:    result = {SEL_0, 1'b0};
        endcase
        return result;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [COUNT_W-1:0]   count_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [SEL_WIDTH-1:0] out_sel_r;
    logic                 out_hit_r;
    logic                 miss_sticky_r;

    // -----------------------------------------------------------------------
    // Next-state signals
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] enc_s;
    logic               push_s;
    logic               pop_s;
    logic               miss_accept_s;
    logic [COUNT_W-1:0] count_next_s;
    logic [PTR_W-1:0]   wr_ptr_next_s;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    logic [ENTRY_W-1:0] head_next_s;

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_sel     = out_sel_r;
    assign out_hit     = out_hit_r;
    assign miss_sticky = miss_sticky_r;

    // Handshakes, occupancy and pointer next-state
    always_comb begin
        enc_s         = encode_value(in_value);
        // Ready comes from the registered full flag: no pass-through when full.
        push_s        = in_valid & in_ready_r;
        pop_s         = out_valid_r & out_ready;
        miss_accept_s = push_s & ~enc_s[0];

        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase

        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Head value after this edge: the slot being written this cycle is
    // forwarded when it becomes the head (push into empty, or push+pop at
    // occupancy 1); an empty FIFO presents zeros.
    always_comb begin
        head_next_s = ENTRY_ZERO;
        if (count_next_s == COUNT_EMPTY) begin
            head_next_s = ENTRY_ZERO;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = enc_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= enc_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and registered handshake/head outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= COUNT_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sel_r   <= SEL_0;
            out_hit_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != COUNT_FULL);
            out_valid_r <= (count_next_s != COUNT_EMPTY);
            out_sel_r   <= head_next_s[ENTRY_W-1:1];
            out_hit_r   <= head_next_s[0];
        end
    end

    // Sticky miss flag: a miss accepted in the same cycle as miss_clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_sticky_r <= 1'b0;
        end else if (miss_accept_s) begin
            miss_sticky_r <= 1'b1;
        end else if (miss_clear) begin
            miss_sticky_r <= 1'b0;
        end else begin
            miss_sticky_r <= miss_sticky_r;
        end
    end

`ifdef SWITCH_VALUE_ENCODER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 hit_accept_s;
    logic [CNT_WIDTH-1:0] hit_count_r;
    logic [CNT_WIDTH-1:0] miss_count_r;

    assign hit_accept_s = push_s & enc_s[0];
    assign hit_count    = hit_count_r;
    assign miss_count   = miss_count_r;

    // Saturating hit counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_r <= CNT_ZERO;
        end else if (hit_accept_s && (hit_count_r != CNT_MAX)) begin
            hit_count_r <= hit_count_r + CNT_ONE;
        end else begin
            hit_count_r <= hit_count_r;
        end
    end

    // Saturating miss counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_count_r <= CNT_ZERO;
        end else if (miss_accept_s && (miss_count_r != CNT_MAX)) begin
            miss_count_r <= miss_count_r + CNT_ONE;
        end else begin
            miss_count_r <= miss_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_switch_value_encoder.sv
// ---------------------------------------------------------------------------
// tb_switch_value_encoder
//
// Directed testbench for switch_value_encoder. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at the same point, so every
// sample reflects the state produced by the preceding edge.
// Build with SWITCH_VALUE_ENCODER_STATS_EN defined to include the counter
// test (CNT_WIDTH = 4).
// ---------------------------------------------------------------------------
module tb_switch_value_encoder;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sel;
    logic       out_hit;
    logic       miss_sticky;
    logic       miss_clear;
`ifdef SWITCH_VALUE_ENCODER_STATS_EN
    logic [3:0] hit_count;
    logic [3:0] miss_count;
`endif

    int tests_run;
    int tests_failed;

`ifdef SWITCH_VALUE_ENCODER_STATS_EN
    switch_value_encoder #(
        .DATA_WIDTH (8),
        .SEL_WIDTH  (3),
        .FIFO_DEPTH (2),
        .CNT_WIDTH  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .out_hit     (out_hit),
        .miss_sticky (miss_sticky),
        .miss_clear  (miss_clear),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );
`else
    switch_value_encoder #(
        .DATA_WIDTH (8),
        .SEL_WIDTH  (3),
        .FIFO_DEPTH (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .out_hit     (out_hit),
        .miss_sticky (miss_sticky),
        .miss_clear  (miss_clear)
    );
`endif

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts the check and reports any mismatch
    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Back-to-back table values and their expected selectors
    logic [7:0] vec_value [4];
    logic [2:0] vec_sel   [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        vec_value[0] = 8'd17; vec_sel[0] = 3'd0;
        vec_value[1] = 8'd22; vec_sel[1] = 3'd1;
        vec_value[2] = 8'd30; vec_sel[2] = 3'd2;
        vec_value[3] = 8'd72; vec_sel[3] = 3'd3;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_value   = 8'd0;
        out_ready  = 1'b0;
        miss_clear = 1'b0;
        step();
        step();

        // Reset state
        check_value("rst_in_ready",    32'(in_ready),    32'd1);
        check_value("rst_out_valid",   32'(out_valid),   32'd0);
        check_value("rst_out_sel",     32'(out_sel),     32'd0);
        check_value("rst_out_hit",     32'(out_hit),     32'd0);
        check_value("rst_miss_sticky", 32'(miss_sticky), 32'd0);
        reset = 1'b0;
        step();

        // 1: back-to-back table hits, each visible one cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_value = vec_value[i];
            check_value("t1_in_ready", 32'(in_ready), 32'd1);
            step();
            check_value("t1_out_valid", 32'(out_valid), 32'd1);
            check_value("t1_out_sel",   32'(out_sel),   32'(vec_sel[i]));
            check_value("t1_out_hit",   32'(out_hit),   32'd1);
        end
        in_valid = 1'b0;
        step();
        check_value("t1_drained_valid", 32'(out_valid), 32'd0);
        check_value("t1_drained_sel",   32'(out_sel),   32'd0);

        // 2: miss sets the sticky flag; miss_clear clears it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 8'd99;
        step();
        in_valid = 1'b0;
        check_value("t2_out_valid", 32'(out_valid),   32'd1);
        check_value("t2_out_sel",   32'(out_sel),     32'd0);
        check_value("t2_out_hit",   32'(out_hit),     32'd0);
        check_value("t2_sticky",    32'(miss_sticky), 32'd1);
        out_ready  = 1'b1;
        miss_clear = 1'b1;
        step();
        miss_clear = 1'b0;
        out_ready  = 1'b0;
        check_value("t2_cleared",   32'(miss_sticky), 32'd0);
        check_value("t2_popped",    32'(out_valid),   32'd0);

        // 3: backpressure holds the third value until space opens
        in_valid = 1'b1;
        in_value = 8'd17;
        step();
        check_value("t3_ready_1", 32'(in_ready), 32'd1);
        in_value = 8'd22;
        step();
        check_value("t3_full_ready", 32'(in_ready),  32'd0);
        check_value("t3_full_sel",   32'(out_sel),   32'd0);
        in_value = 8'd30;
        step();
        check_value("t3_held_ready", 32'(in_ready),  32'd0);
        check_value("t3_held_sel",   32'(out_sel),   32'd0);
        out_ready = 1'b1;
        step();
        check_value("t3_pop0_sel",   32'(out_sel),   32'd1);
        check_value("t3_pop0_ready", 32'(in_ready),  32'd1);
        step();
        check_value("t3_pop1_sel",   32'(out_sel),   32'd2);
        check_value("t3_pop1_hit",   32'(out_hit),   32'd1);
        check_value("t3_pop1_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check_value("t3_empty", 32'(out_valid), 32'd0);

        // 4: miss and miss_clear in the same cycle: set wins
        in_valid   = 1'b1;
        in_value   = 8'd5;
        miss_clear = 1'b1;
        step();
        in_valid   = 1'b0;
        miss_clear = 1'b0;
        check_value("t4_sticky", 32'(miss_sticky), 32'd1);
        check_value("t4_hit",    32'(out_hit),     32'd0);
        step();
        check_value("t4_sticky_hold", 32'(miss_sticky), 32'd1);
        check_value("t4_empty",       32'(out_valid),   32'd0);

        // 5: asynchronous reset with two entries queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 8'd17;
        step();
        in_value = 8'd22;
        step();
        in_valid = 1'b0;
        check_value("t5_full_ready", 32'(in_ready),  32'd0);
        check_value("t5_full_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_value("t5_async_valid",  32'(out_valid),   32'd0);
        check_value("t5_async_ready",  32'(in_ready),    32'd1);
        check_value("t5_async_sticky", 32'(miss_sticky), 32'd0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 8'd22;
        step();
        in_valid = 1'b0;
        check_value("t5_after_sel",   32'(out_sel),   32'd1);
        check_value("t5_after_hit",   32'(out_hit),   32'd1);
        check_value("t5_after_valid", 32'(out_valid), 32'd1);
        step();
        check_value("t5_after_empty", 32'(out_valid), 32'd0);

`ifdef SWITCH_VALUE_ENCODER_STATS_EN
        // 6: counters saturate at 15 with a 4-bit width
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("t6_rst_hits", 32'(hit_count),  32'd0);
        check_value("t6_rst_miss", 32'(miss_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_value = vec_value[i % 4];
            step();
        end
        in_value = 8'd200;
        step();
        in_valid = 1'b0;
        step();
        check_value("t6_hit_count",  32'(hit_count),  32'd15);
        check_value("t6_miss_count", 32'(miss_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
